aes128_enc_iter: RTL
====================

# aes128_enc_iter

Iterative AES-128 encryption core: accepts a 128-bit key and plaintext block, performs the initial AddRoundKey plus 10 forward rounds at one round per clock, and returns the ciphertext. Round keys are expanded on the fly, one per round. It is the encrypt-direction counterpart of the decryption datapath inside the AES IP, and it connects to the AXI register wrapper through valid/ready handshakes.

## Interface
- No parameters. Nr = 10 and the block size are fixed constants in the package.
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  key/plaintext offered
- in_ready  out  1  core idle and able to accept
- key  in  128  cipher key; [127:120] = byte 0 (FIPS-197 order, column-major)
- plaintext  in  128  input block, same byte order
- out_valid  out  1  ciphertext available
- out_ready  in  1  consumer accepts ciphertext
- ciphertext  out  128  result, same byte order
- busy  out  1  high while rounds are executing

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&in_ready:
  - state_reg <= plaintext ^ key
  - key_reg <= key
  - rnd <= 1
  - go to RUN.
- RUN: each cycle:
  - next_key = expand(key_reg, rcon[rnd])
  - state_reg <= enc_round(state_reg, next_key, final=(rnd==10))
  - key_reg <= next_key
  - rnd <= rnd+1
  - After the rnd==10 update, go to DONE.
- enc_round order: SubBytes → ShiftRows → MixColumns (skipped when final) → AddRoundKey.
- Key expansion step:
  - w0' = w0 ^ SubWord(RotWord(w3)) ^ {rcon,24'h0}
  - w1' = w1^w0'
  - w2' = w2^w1'
  - w3' = w3^w2'
  - w0 = key_reg[127:96].
- rcon for rnd 1..10: 01,02,04,08,10,20,40,80,1b,36.
- MixColumns arithmetic: GF(2^8) with xtime reduction polynomial 0x11b. All byte ops are 8-bit; no carries cross bytes.
- DONE: out_valid=1, ciphertext=state_reg, held stable until out_valid&out_ready, then go to IDLE.
- rnd is a 4-bit counter. Values 0 and 11–15 are never used in RUN.
- in_ready=0 in RUN and DONE. in_valid there is ignored, and key/plaintext are not sampled.
- A new block is never accepted in the same cycle as the output handshake. in_ready rises the cycle after the DONE→IDLE transition.
- busy = (fsm==RUN).
- Inputs are sampled only at the accept edge. Later changes to key/plaintext do not affect an in-flight block.
- Reset values:
  - fsm=IDLE; in_ready=1 in the first cycle after rst is sampled
  - out_valid=0, busy=0, ciphertext=0
  - rnd=0, state_reg=0, key_reg=0.
- rst asserted mid-RUN or in DONE: the block is abandoned and reset values apply after that edge. No out_valid pulse is produced for it.
- rst has priority over every handshake in the same cycle.

## Timing
- Accept at edge T. Rounds 1..10 register at edges T+1..T+10. DONE, with out_valid=1, is entered at edge T+10, and out_valid is visible in cycle T+10..T+11.
- Latency: 10 cycles from the accept edge to out_valid high.
- Minimum period per block: 12 cycles with out_ready held high (accept, 10 rounds, handshake cycle). IDLE is re-entered after the handshake edge.
- out_valid must not drop without a handshake or rst. ciphertext must not change while out_valid=1.
- Critical path: one S-box layer + MixColumns + XOR in parallel with key-expansion S-boxes. The round must close at the IP clock frequency without pipelining.

## Structure
- Package aes_pkg contains:
  - 256-entry S-box function
  - rcon lookup function
  - xtime/gmul helpers
  - NR=10
  - fsm state enum
  - The S-box is shared with the decrypt path's inverse tables in the same package.
- Sub-module enc_round: combinational forward round with a final_round input, the mirror of the decrypt round.
- Key expansion step stays inline in the core: 4 S-boxes plus XORs.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff → ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a; out_valid exactly 10 cycles after accept.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 → 3925841d02dc09fbdc118597196a0b32; internal state after round 1 = a49c7ff2689f352b6b5bea43026a5049.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid → ciphertext and out_valid stable, in_ready=0. Then release → one handshake, and in_ready=1 the following cycle.
- Ignored input: toggle in_valid and change key/plaintext during RUN → the C.1 result is unchanged and no second block is started.
- Reset mid-RUN at round 5 → the next cycle shows in_ready=1, out_valid=0, busy=0. A fresh C.1 block then completes correctly.
- Back-to-back: 4 random blocks, each compared against a reference model, with out_ready=1 → all match, with a block period of 12 cycles.

Source files
------------

// File: rtl/aes_pkg.sv
// ============================================================================
// Module  : aes_pkg
// Brief   : Shared AES constants, forward S-box, rcon and GF(2^8) helpers.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_pkg;

  localparam int NR         = 10;
  localparam int BLOCK_BITS = 128;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } fsm_t;

  // Row-major table: SBOX[x] is the substitution of byte x.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

endpackage

`default_nettype wire

// File: rtl/enc_round.sv
// ============================================================================
// Module  : enc_round
// Brief   : Combinational forward AES round; MixColumns bypassed on the final round.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module enc_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         final_round,
  output logic [127:0] state_out
);

  logic [15:0][7:0] w_sb;
  logic [15:0][7:0] w_sr;
  logic [15:0][7:0] w_mc;

  // Byte i sits at [127-8i -: 8]; index = row + 4*column.
  always_comb begin
    w_sb      = '0;
    w_sr      = '0;
    w_mc      = '0;
    state_out = '0;
    for (int i = 0; i < 16; i++) begin
      w_sb[i] = sbox(state_in[127-8*i -: 8]);
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_sr[r+4*c] = w_sb[r+4*((c+r)%4)];
      end
    end
    for (int c = 0; c < 4; c++) begin
      w_mc[4*c]   = xtime(w_sr[4*c]) ^ xtime(w_sr[4*c+1]) ^ w_sr[4*c+1] ^ w_sr[4*c+2] ^ w_sr[4*c+3];
      w_mc[4*c+1] = w_sr[4*c] ^ xtime(w_sr[4*c+1]) ^ xtime(w_sr[4*c+2]) ^ w_sr[4*c+2] ^ w_sr[4*c+3];
      w_mc[4*c+2] = w_sr[4*c] ^ w_sr[4*c+1] ^ xtime(w_sr[4*c+2]) ^ xtime(w_sr[4*c+3]) ^ w_sr[4*c+3];
      w_mc[4*c+3] = xtime(w_sr[4*c]) ^ w_sr[4*c] ^ w_sr[4*c+1] ^ w_sr[4*c+2] ^ xtime(w_sr[4*c+3]);
    end
    for (int i = 0; i < 16; i++) begin
      state_out[127-8*i -: 8] = (final_round ? w_sr[i] : w_mc[i]) ^ round_key[127-8*i -: 8];
    end
  end

endmodule

`default_nettype wire

// File: rtl/aes128_enc_iter.sv
// ============================================================================
// Module  : aes128_enc_iter
// Brief   : Iterative AES-128 encryptor, one round per clock, on-the-fly key schedule.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module aes128_enc_iter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] key,
  input  logic [127:0] plaintext,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic         busy
);

  fsm_t         r_fsm;
  logic [127:0] r_state;
  logic [127:0] r_key;
  logic [3:0]   r_rnd;
  logic         r_in_ready;
  logic         r_out_valid;
  logic         r_busy;

  logic [31:0]  w_rot;
  logic [31:0]  w_sub;
  logic [31:0]  w_k0, w_k1, w_k2, w_k3;
  logic [127:0] w_next_key;
  logic [127:0] w_round;
  logic         w_final;

  assign w_rot = {r_key[23:0], r_key[31:24]};
  assign w_sub = {sbox(w_rot[31:24]), sbox(w_rot[23:16]), sbox(w_rot[15:8]), sbox(w_rot[7:0])};
  assign w_k0  = r_key[127:96] ^ w_sub ^ {rcon(r_rnd), 24'h0};
  assign w_k1  = r_key[95:64] ^ w_k0;
  assign w_k2  = r_key[63:32] ^ w_k1;
  assign w_k3  = r_key[31:0]  ^ w_k2;
  assign w_next_key = {w_k0, w_k1, w_k2, w_k3};
  assign w_final    = (r_rnd == 4'(NR));

  enc_round u_enc_round (
    .state_in   (r_state),
    .round_key  (w_next_key),
    .final_round(w_final),
    .state_out  (w_round)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm       <= S_IDLE;
      r_state     <= '0;
      r_key       <= '0;
      r_rnd       <= 4'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_fsm)
        S_IDLE: begin
          if (in_valid) begin
            r_state    <= plaintext ^ key;
            r_key      <= key;
            r_rnd      <= 4'd1;
            r_fsm      <= S_RUN;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        S_RUN: begin
          r_state <= w_round;
          r_key   <= w_next_key;
          r_rnd   <= r_rnd + 4'd1;
          if (w_final) begin
            r_fsm       <= S_DONE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          // in_ready only returns next cycle, so no accept overlaps the handshake.
          if (out_ready) begin
            r_fsm       <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_fsm       <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign busy       = r_busy;
  assign ciphertext = r_state;

endmodule

`default_nettype wire
